// File: rtl/control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : control_fsm
//  Purpose  : Multicycle LC-3b control unit. Sequences fetch, decode and
//             execute for ADD/AND/NOT/BR/JMP/LDR/STR, drives datapath load
//             enables, mux selects, ALU op and memory strobes, and waits on
//             mem_resp for every memory access.
//  Options  : CTRL_INSTRET_EN - when defined, instret_count counts retired
//             instructions (wrapping 16-bit). Otherwise it is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module control_fsm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  opcode,
    input  logic        instruction5,
    input  logic        branch_enable,
    input  logic        mem_resp,
    output logic        load_pc,
    output logic        load_ir,
    output logic        load_regfile,
    output logic        load_mar,
    output logic        load_mdr,
    output logic        load_cc,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  pcmux_sel,
    output logic        marmux_sel,
    output logic        mdrmux_sel,
    output logic        regfilemux_sel,
    output logic        storemux_sel,
    output logic [1:0]  alumux_sel,
    output logic [2:0]  aluop,
    output logic [15:0] instret_count
);

    // Opcode encodings taken from IR[15:12]
    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_JMP = 4'b1100;

    // Select and ALU-op encodings
    localparam logic [1:0] PCMUX_PLUS2  = 2'd0;
    localparam logic [1:0] PCMUX_BRADD  = 2'd1;
    localparam logic [1:0] PCMUX_ALU    = 2'd2;
    localparam logic [1:0] ALUMUX_SR2   = 2'd0;
    localparam logic [1:0] ALUMUX_IMM5  = 2'd1;
    localparam logic [1:0] ALUMUX_OFF6  = 2'd2;
    localparam logic [2:0] ALU_ADD      = 3'd0;
    localparam logic [2:0] ALU_AND      = 3'd1;
    localparam logic [2:0] ALU_NOT      = 3'd2;
    localparam logic [2:0] ALU_PASS     = 3'd3;

    typedef enum logic [3:0] {
        S_FETCH1   = 4'd0,
        S_FETCH2   = 4'd1,
        S_FETCH3   = 4'd2,
        S_DECODE   = 4'd3,
        S_ADD      = 4'd4,
        S_AND      = 4'd5,
        S_NOT      = 4'd6,
        S_BR       = 4'd7,
        S_BR_TAKEN = 4'd8,
        S_JMP      = 4'd9,
        S_LDR1     = 4'd10,
        S_LDR2     = 4'd11,
        S_LDR3     = 4'd12,
        S_STR1     = 4'd13,
        S_STR2     = 4'd14,
        S_STR3     = 4'd15
    } state_t;

    state_t state;
    state_t next_state;

    // State register; reset parks the machine at the start of fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH1;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; mem_resp only matters in the three memory-wait states
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH1:   next_state = S_FETCH2;
            S_FETCH2:   if (mem_resp) next_state = S_FETCH3;
            S_FETCH3:   next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_ADD:  next_state = S_ADD;
                    OP_AND:  next_state = S_AND;
                    OP_NOT:  next_state = S_NOT;
                    OP_BR:   next_state = S_BR;
                    OP_JMP:  next_state = S_JMP;
                    OP_LDR:  next_state = S_LDR1;
                    OP_STR:  next_state = S_STR1;
                    // Unsupported opcodes retire as a NOP
                    default: next_state = S_FETCH1;
                endcase
            end
            S_ADD:      next_state = S_FETCH1;
            S_AND:      next_state = S_FETCH1;
            S_NOT:      next_state = S_FETCH1;
            S_BR:       next_state = branch_enable ? S_BR_TAKEN : S_FETCH1;
            S_BR_TAKEN: next_state = S_FETCH1;
            S_JMP:      next_state = S_FETCH1;
            S_LDR1:     next_state = S_LDR2;
            S_LDR2:     if (mem_resp) next_state = S_LDR3;
            S_LDR3:     next_state = S_FETCH1;
            S_STR1:     next_state = S_STR2;
            S_STR2:     next_state = S_STR3;
            S_STR3:     if (mem_resp) next_state = S_FETCH1;
            default:    next_state = S_FETCH1;
        endcase
    end

    // Moore output decode; everything is held at zero while reset is asserted
    // so strobes drop immediately even in the middle of a memory wait
    always_comb begin
        load_pc        = 1'b0;
        load_ir        = 1'b0;
        load_regfile   = 1'b0;
        load_mar       = 1'b0;
        load_mdr       = 1'b0;
        load_cc        = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        pcmux_sel      = PCMUX_PLUS2;
        marmux_sel     = 1'b0;
        mdrmux_sel     = 1'b0;
        regfilemux_sel = 1'b0;
        storemux_sel   = 1'b0;
        alumux_sel     = ALUMUX_SR2;
        aluop          = ALU_ADD;
        if (rst_n) begin
            case (state)
                S_FETCH1: begin
                    load_mar   = 1'b1;
                    marmux_sel = 1'b1;
                    load_pc    = 1'b1;
                    pcmux_sel  = PCMUX_PLUS2;
                end
                S_FETCH2: begin
                    mem_read   = 1'b1;
                    mdrmux_sel = 1'b1;
                    load_mdr   = 1'b1;
                end
                S_FETCH3: begin
                    load_ir = 1'b1;
                end
                S_ADD: begin
                    load_regfile   = 1'b1;
                    load_cc        = 1'b1;
                    regfilemux_sel = 1'b0;
                    aluop          = ALU_ADD;
                    alumux_sel     = instruction5 ? ALUMUX_IMM5 : ALUMUX_SR2;
                end
                S_AND: begin
                    load_regfile   = 1'b1;
                    load_cc        = 1'b1;
                    regfilemux_sel = 1'b0;
                    aluop          = ALU_AND;
                    alumux_sel     = instruction5 ? ALUMUX_IMM5 : ALUMUX_SR2;
                end
                S_NOT: begin
                    load_regfile = 1'b1;
                    load_cc      = 1'b1;
                    aluop        = ALU_NOT;
                end
                S_BR_TAKEN: begin
                    load_pc   = 1'b1;
                    pcmux_sel = PCMUX_BRADD;
                end
                S_JMP: begin
                    load_pc   = 1'b1;
                    pcmux_sel = PCMUX_ALU;
                    aluop     = ALU_PASS;
                end
                S_LDR1, S_STR1: begin
                    // Effective address = base + (SEXT(offset6) << 1)
                    load_mar   = 1'b1;
                    marmux_sel = 1'b0;
                    alumux_sel = ALUMUX_OFF6;
                    aluop      = ALU_ADD;
                end
                S_LDR2: begin
                    mem_read   = 1'b1;
                    mdrmux_sel = 1'b1;
                    load_mdr   = 1'b1;
                end
                S_LDR3: begin
                    load_regfile   = 1'b1;
                    regfilemux_sel = 1'b1;
                    load_cc        = 1'b1;
                end
                S_STR2: begin
                    // Route the source register (held in the dest field) to MDR
                    storemux_sel = 1'b1;
                    aluop        = ALU_PASS;
                    mdrmux_sel   = 1'b0;
                    load_mdr     = 1'b1;
                end
                S_STR3: begin
                    storemux_sel = 1'b1;
                    mem_write    = 1'b1;
                end
                default: begin
                    // DECODE and BR assert nothing
                end
            endcase
        end
    end

`ifdef CTRL_INSTRET_EN
    logic        retire;
    logic [15:0] instret_q;

    // An instruction retires whenever execution (not fetch) hands back to FETCH1
    assign retire = (next_state == S_FETCH1) &&
                    (state != S_FETCH1) &&
                    (state != S_FETCH2) &&
                    (state != S_FETCH3);

    // Retired-instruction counter, free-running with natural 16-bit wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= 16'h0000;
        end else if (retire) begin
            instret_q <= instret_q + 16'd1;
        end
    end

    assign instret_count = instret_q;
`else
    assign instret_count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: doc/control_fsm.md
# control_fsm

Multicycle LC-3b control unit that sequences the datapath for fetch, decode and execute. It drives the load enables, mux selects, ALU op and memory strobes, and handshakes with memory through `mem_resp`. It reads the decoded instruction fields from the instruction register and returns to fetch after every instruction.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  clock, all state changes on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `opcode`  in  4  IR[15:12]
- `instruction5`  in  1  IR[5], the immediate-mode flag for ADD and AND
- `branch_enable`  in  1  NZP match from CC compare, combinational
- `mem_resp`  in  1  memory completed current read/write this cycle
- `load_pc`, `load_ir`, `load_regfile`, `load_mar`, `load_mdr`, `load_cc`  out  1 each  register load enables
- `mem_read`, `mem_write`  out  1 each  memory strobes
- `pcmux_sel`  out  2  0 = PC+2, 1 = PC+(SEXT(offset9)<<1), 2 = ALU out
- `marmux_sel`  out  1  0 = ALU out, 1 = PC
- `mdrmux_sel`  out  1  0 = ALU out, 1 = mem_rdata
- `regfilemux_sel`  out  1  0 = ALU out, 1 = MDR
- `storemux_sel`  out  1  0 = SR1 read port addresses src1, 1 = addresses dest
- `alumux_sel`  out  2  0 = SR2, 1 = SEXT(imm5), 2 = SEXT(offset6)<<1
- `aluop`  out  3  0 = ADD, 1 = AND, 2 = NOT, 3 = PASS (A operand)
- `instret_count`  out  16  retired-instruction counter (see Configuration)

## Operation
- Moore FSM. Outputs are decoded from the current state only, except the `alumux_sel` and `mem_resp`-dependent transitions noted below. Any output not listed for a state is 0.
- States and actions:
  - FETCH1: `load_mar`, `marmux_sel`=1, `load_pc`, `pcmux_sel`=0. Next: FETCH2.
  - FETCH2: `mem_read`, `mdrmux_sel`=1, `load_mdr`. Stays in FETCH2 while `mem_resp`=0, then goes to FETCH3.
  - FETCH3: `load_ir`. Next: DECODE.
  - DECODE: no outputs asserted. Next by `opcode`: 0001 to ADD, 0101 to AND, 1001 to NOT, 0000 to BR, 1100 to JMP, 0110 to LDR1, 0111 to STR1. Any other opcode goes to FETCH1 (executes as NOP).
  - ADD / AND: `load_regfile`, `load_cc`, `regfilemux_sel`=0, `aluop`=0 or 1. `alumux_sel` = `instruction5` ? 1 : 0. Next: FETCH1.
  - NOT: `load_regfile`, `load_cc`, `aluop`=2. Next: FETCH1.
  - BR: no outputs asserted. Next: BR_TAKEN if `branch_enable`, else FETCH1.
  - BR_TAKEN: `load_pc`, `pcmux_sel`=1. Next: FETCH1.
  - JMP: `load_pc`, `pcmux_sel`=2, `aluop`=3. Next: FETCH1.
  - LDR1 / STR1: `load_mar`, `marmux_sel`=0, `alumux_sel`=2, `aluop`=0. Next: LDR2 / STR2.
  - LDR2: `mem_read`, `mdrmux_sel`=1, `load_mdr`. Waits on `mem_resp`, then goes to LDR3.
  - LDR3: `load_regfile`, `regfilemux_sel`=1, `load_cc`. Next: FETCH1.
  - STR2: `storemux_sel`=1, `aluop`=3, `mdrmux_sel`=0, `load_mdr`. Next: STR3.
  - STR3: `storemux_sel`=1, `mem_write`. Waits on `mem_resp`, then goes to FETCH1.
- `mem_read` and `mem_write` are never asserted in the same cycle. Each strobe stays high, unchanged, until the cycle in which `mem_resp`=1.
- `mem_resp` is ignored in all states other than FETCH2, LDR2 and STR3.

## Timing
- Reset: `rst_n` low asynchronously forces state to FETCH1. All outputs are forced to 0 and `instret_count` is cleared to 0 while `rst_n` is low. The first FETCH1 actions occur in the first cycle after deassertion.
- Reset asserted mid-instruction, including during a memory wait, abandons the instruction and drops the strobes immediately.
- Cycle counts with `mem_resp` returned in the first wait cycle:
  - ADD, AND, NOT, JMP: 5
  - BR not taken: 5
  - BR taken: 6
  - LDR: 7
  - STR: 7
  - illegal opcode: 4
- Each extra wait cycle adds 1.
- `mem_resp` high in the first FETCH2 cycle advances to FETCH3 on the next edge. No minimum wait is imposed.

## Configuration
- `CTRL_INSTRET_EN` defined: `instret_count` increments by 1 on each edge where the FSM enters FETCH1 from any state other than FETCH1/FETCH2/FETCH3. Illegal-opcode NOPs are counted. The counter wraps from 0xFFFF to 0x0000.
- `CTRL_INSTRET_EN` undefined: the port is still present and tied to 16'h0000. No counter flops are synthesized.

## Test plan
- Reset with `rst_n` low mid-FETCH2 and `mem_read`=1: outputs drop to 0 immediately. After release, cycle 1 shows `load_mar`=1, `marmux_sel`=1, `load_pc`=1.
- ADD imm (`opcode`=0001, `instruction5`=1), `mem_resp` after 3 wait cycles: FETCH2 held 3 cycles. The ADD state shows `alumux_sel`=1, `load_regfile`=1, `load_cc`=1. Total 7 cycles.
- BR with `branch_enable`=0 takes 5 cycles and no `pcmux_sel`=1. With `branch_enable`=1, `load_pc`=1 and `pcmux_sel`=1 appear in cycle 6.
- LDR then STR, 1-cycle memory:
  - LDR3 shows `regfilemux_sel`=1.
  - STR3 shows `mem_write`=1 and `storemux_sel`=1.
  - `mem_read` and `mem_write` are never high together.
  - 7 cycles each.
- `opcode`=1101 (illegal): DECODE goes directly to FETCH1, with no load other than the fetch loads. 4 cycles.
- With `CTRL_INSTRET_EN`: 3 instructions give `instret_count`=3. Preloaded at 0xFFFF via forced state, it wraps to 0x0000. Without the macro, it reads 0 throughout.
